fetch_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Keeps the fetch PC and drives a request/acknowledge instruction-memory port.
- Produces the F/D pipeline register (fd_pc, fd_instr) consumed by decode.
- Obeys decode's stall (hold F/D) and branch redirect (flush and refetch), and inserts NOP bubbles whenever no instruction is available.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_pkg : shared constants and FSM encoding for fetch      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC, imem req/ack port, skid buffer and F/D register  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        fd_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  stale_q, stale_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  fd_pc_q, fd_pc_d;
  logic [31:0]  fd_instr_q, fd_instr_d;
  logic         fd_valid_q, fd_valid_d;

  logic w_redirect;
  logic w_req_raw;
  logic w_accept;
  logic w_unused_bpc;

  assign w_unused_bpc = ^branch_PC[1:0];
  assign w_redirect   = branch_en && !stall;

  always_comb begin
    w_req_raw = 1'b0;
    imem_addr = pc_q;
    if (state_q == DROP) begin
      w_req_raw = 1'b1;
      imem_addr = stale_q;
    end else begin
      w_req_raw = !buf_valid_q;
      imem_addr = pc_q;
    end
  end

  assign imem_req = w_req_raw && !reset;
  assign w_accept = imem_ack && w_req_raw && (state_q == FETCH) && !w_redirect;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    fd_pc_d     = fd_pc_q;
    fd_instr_d  = fd_instr_q;
    fd_valid_d  = fd_valid_q;

    if (w_redirect) begin
      pc_d        = {branch_PC[31:2], 2'b00};
      buf_valid_d = 1'b0;
      fd_pc_d     = 32'h0;
      fd_instr_d  = NOP_INSTR;
      fd_valid_d  = 1'b0;
      // An unacknowledged request must still complete; park its address.
      if (state_q == FETCH) begin
        if (w_req_raw && !imem_ack) begin
          state_d = DROP;
          stale_d = pc_q;
        end
      end else if (imem_ack) begin
        state_d = FETCH;
      end
    end else begin
      if (state_q == DROP && imem_ack) begin
        state_d = FETCH;
      end
      if (w_accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (!stall) begin
        if (buf_valid_q) begin
          fd_pc_d     = buf_pc_q;
          fd_instr_d  = buf_instr_q;
          fd_valid_d  = 1'b1;
          buf_valid_d = 1'b0;
        end else if (w_accept) begin
          fd_pc_d    = pc_q;
          fd_instr_d = imem_rdata;
          fd_valid_d = 1'b1;
        end else begin
          fd_pc_d    = 32'h0;
          fd_instr_d = NOP_INSTR;
          fd_valid_d = 1'b0;
        end
      end else if (w_accept) begin
        buf_pc_d    = pc_q;
        buf_instr_d = imem_rdata;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      stale_q     <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= NOP_INSTR;
      fd_pc_q     <= 32'h0;
      fd_instr_q  <= NOP_INSTR;
      fd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stale_q     <= stale_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      fd_pc_q     <= fd_pc_d;
      fd_instr_q  <= fd_instr_d;
      fd_valid_q  <= fd_valid_d;
    end
  end

  assign fd_pc    = fd_pc_q;
  assign fd_instr = fd_instr_q;
  assign fd_valid = fd_valid_q;

endmodule
`default_nettype wire
